// File: rtl/inv_alu_if.sv
// Bundle of the inv_alu start/busy/done handshake, operand bus and debug state.
// Handshake: start is taken only while idle; busy is high while working; done pulses one cycle with opA/rem/err valid.
interface inv_alu_if;
  logic        start;
  logic        opcode;
  logic [15:0] res;
  logic [7:0]  opB;
  logic [7:0]  opA;
  logic [7:0]  rem;
  logic        err;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  modport master (
    output start, opcode, res, opB,
    input  opA, rem, err, busy, done, dbg_state
  );

  modport slave (
    input  start, opcode, res, opB,
    output opA, rem, err, busy, done, dbg_state
  );
endinterface

// File: rtl/inv_alu.sv
// Sequential inverse of the 8-bit ALU: undoes add by subtraction, multiply by restoring division.
// Optional macro INV_ALU_REM_EN keeps the remainder register; otherwise rem reads 0.
module inv_alu (
  input  logic       clk,
  input  logic       rst,
  inv_alu_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;   // latched res; becomes the quotient shift register in DIV
  logic [7:0]  opb_q, opb_d;
  logic [7:0]  prem_q, prem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  opa_q, opa_d;
  logic        err_q, err_d;
`ifdef INV_ALU_REM_EN
  logic [7:0]  rem_q, rem_d;
`endif

  logic [16:0] diff;
  logic [8:0]  trial;
  logic        fits;
  logic [15:0] quo_nxt;
  logic [7:0]  prem_nxt;

  // One restoring step: the 9-bit trial never exceeds 2*opB-1, so the kept remainder fits in 8 bits.
  always_comb begin
    diff     = {1'b0, work_q} - {9'b0, opb_q};
    trial    = {prem_q, work_q[15]};
    fits     = (trial >= {1'b0, opb_q});
    quo_nxt  = {work_q[14:0], fits};
    prem_nxt = fits ? 8'(trial - {1'b0, opb_q}) : trial[7:0];
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    opb_d   = opb_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    err_d   = err_q;
`ifdef INV_ALU_REM_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.res;
          opb_d  = bus.opB;
          prem_d = 8'h00;
          cnt_d  = 4'd0;
          if (!bus.opcode) begin
            state_d = SUB;
          end else if (bus.opB != 8'h00) begin
            state_d = DIV;
          end else begin
            opa_d   = 8'hFF;
            err_d   = 1'b1;
`ifdef INV_ALU_REM_EN
            rem_d   = bus.res[7:0];
`endif
            state_d = DONE;
          end
        end
      end
      SUB: begin
        opa_d   = diff[7:0];
        err_d   = (work_q < {8'h00, opb_q}) || (|diff[16:8]);
`ifdef INV_ALU_REM_EN
        rem_d   = 8'h00;
`endif
        state_d = DONE;
      end
      DIV: begin
        work_d = quo_nxt;
        prem_d = prem_nxt;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          opa_d   = quo_nxt[7:0];
          err_d   = |quo_nxt[15:8];
`ifdef INV_ALU_REM_EN
          rem_d   = prem_nxt;
`endif
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      opb_q   <= 8'h00;
      prem_q  <= 8'h00;
      cnt_q   <= 4'd0;
      opa_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      err_q   <= err_d;
    end
  end

`ifdef INV_ALU_REM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= 8'h00;
    else     rem_q <= rem_d;
  end
  assign bus.rem = rem_q;
`else
  assign bus.rem = 8'h00;
`endif

  assign bus.opA       = opa_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == SUB) || (state_q == DIV);
  assign bus.done      = (state_q == DONE);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_inv_alu.sv
// Directed bench for inv_alu: subtract/divide paths, boundaries, divide by zero, handshake and reset.
module tb_inv_alu;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  inv_alu_if bus ();
  inv_alu dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INV_ALU_REM_EN
  localparam logic [7:0] REM_MUL  = 8'd5;
  localparam logic [7:0] REM_DIV0 = 8'h34;
`else
  localparam logic [7:0] REM_MUL  = 8'd0;
  localparam logic [7:0] REM_DIV0 = 8'd0;
`endif

  task automatic pulse_start(input logic op, input logic [15:0] r, input logic [7:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.res    = r;
    bus.opB    = b;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Counts negedges until done, with a bound; lat stays at 40 on timeout.
  task automatic wait_done(output int lat, output int busy_n, output int overlap);
    lat = 0; busy_n = 0; overlap = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.opA !== 8'h00) begin failures++; $display("FAIL reset_opA got=%h exp=00", bus.opA); end
    checks++; if (bus.rem !== 8'h00) begin failures++; $display("FAIL reset_rem got=%h exp=00", bus.rem); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
  endtask

  task automatic test_inv_add;
    int lat, bn, ov;
    pulse_start(1'b0, 16'd100, 8'd33);
    wait_done(lat, bn, ov);
    checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (bn != 1) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=1", bn); end
    checks++; if (ov != 0) begin failures++; $display("FAIL add_busy_done_overlap got=%0d exp=0", ov); end
    checks++; if (bus.opA !== 8'd67) begin failures++; $display("FAIL add_opA got=%0d exp=67", bus.opA); end
    checks++; if (bus.rem !== 8'd0) begin failures++; $display("FAIL add_rem got=%0d exp=0", bus.rem); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL add_err got=%b exp=0", bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL add_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.opA !== 8'd67) begin failures++; $display("FAIL add_opA_hold got=%0d exp=67", bus.opA); end
  endtask

  task automatic test_inv_mul;
    int lat, bn, ov;
    pulse_start(1'b1, 16'h8AD3, 8'hDA);
    wait_done(lat, bn, ov);
    checks++; if (lat != 16) begin failures++; $display("FAIL mul_latency got=%0d exp=16", lat); end
    checks++; if (bn != 16) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=16", bn); end
    checks++; if (ov != 0) begin failures++; $display("FAIL mul_busy_done_overlap got=%0d exp=0", ov); end
    checks++; if (bus.opA !== 8'hA3) begin failures++; $display("FAIL mul_opA got=%h exp=a3", bus.opA); end
    checks++; if (bus.rem !== REM_MUL) begin failures++; $display("FAIL mul_rem got=%0d exp=%0d", bus.rem, REM_MUL); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mul_err got=%b exp=0", bus.err); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_boundaries;
    int lat, bn, ov;
    pulse_start(1'b0, 16'd10, 8'd20);
    wait_done(lat, bn, ov);
    checks++; if (bus.opA !== 8'hF6) begin failures++; $display("FAIL underflow_opA got=%h exp=f6", bus.opA); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", bus.err); end
    pulse_start(1'b1, 16'h1000, 8'd1);
    wait_done(lat, bn, ov);
    checks++; if (lat != 16) begin failures++; $display("FAIL overflow_latency got=%0d exp=16", lat); end
    checks++; if (bus.opA !== 8'h00) begin failures++; $display("FAIL overflow_opA got=%h exp=00", bus.opA); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", bus.err); end
    checks++; if (bus.rem !== 8'h00) begin failures++; $display("FAIL overflow_rem got=%h exp=00", bus.rem); end
  endtask

  task automatic test_div_zero;
    int lat, bn, ov;
    pulse_start(1'b1, 16'h1234, 8'd0);
    wait_done(lat, bn, ov);
    checks++; if (lat != 0) begin failures++; $display("FAIL div0_latency got=%0d exp=0", lat); end
    checks++; if (bn != 0) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=0", bn); end
    checks++; if (ov != 0) begin failures++; $display("FAIL div0_busy_done_overlap got=%0d exp=0", ov); end
    checks++; if (bus.opA !== 8'hFF) begin failures++; $display("FAIL div0_opA got=%h exp=ff", bus.opA); end
    checks++; if (bus.rem !== REM_DIV0) begin failures++; $display("FAIL div0_rem got=%h exp=%h", bus.rem, REM_DIV0); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL div0_err got=%b exp=1", bus.err); end
  endtask

  task automatic test_back_to_back;
    int lat, bn, ov, tries;
    pulse_start(1'b0, 16'd300, 8'd45);
    wait_done(lat, bn, ov);
    checks++; if (bus.opA !== 8'd255 || bus.err !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=255/0", bus.opA, bus.err); end
    bus.start = 1'b1;
    bus.res   = 16'd301;
    tries = 0;
    while (bus.busy !== 1'b1 && tries < 5) begin
      @(negedge clk);
      tries++;
    end
    bus.start = 1'b0;
    checks++; if (tries >= 5) begin failures++; $display("FAIL b2b_accept got=timeout exp=busy"); end
    wait_done(lat, bn, ov);
    checks++; if (lat != 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
    checks++; if (bus.opA !== 8'h00 || bus.err !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h/%b exp=00/1", bus.opA, bus.err); end
  endtask

  task automatic test_ignore_start;
    int lat, bn, ov;
    pulse_start(1'b1, 16'h8AD3, 8'hDA);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", bus.busy); end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 1'b0;
    bus.res    = 16'd2211;
    bus.opB    = 8'd33;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(lat, bn, ov);
    checks++; if (lat != 14) begin failures++; $display("FAIL ignore_latency got=%0d exp=14", lat); end
    checks++; if (bus.opA !== 8'hA3) begin failures++; $display("FAIL ignore_opA got=%h exp=a3", bus.opA); end
    checks++; if (bus.rem !== REM_MUL) begin failures++; $display("FAIL ignore_rem got=%0d exp=%0d", bus.rem, REM_MUL); end
    @(negedge clk);
    checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL ignore_no_queue got=%0d exp=0", bus.dbg_state); end
  endtask

  task automatic test_reset_mid_div;
    int done_n, lat, bn, ov;
    pulse_start(1'b1, 16'h8AD3, 8'hDA);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.opA !== 8'h00) begin failures++; $display("FAIL rst_mid_opA got=%h exp=00", bus.opA); end
    checks++; if (bus.rem !== 8'h00) begin failures++; $display("FAIL rst_mid_rem got=%h exp=00", bus.rem); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_done got=%b%b exp=00", bus.busy, bus.done); end
    checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", bus.dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_n++;
    end
    checks++; if (done_n != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_n); end
    pulse_start(1'b1, 16'd2211, 8'd33);
    wait_done(lat, bn, ov);
    checks++; if (lat != 16) begin failures++; $display("FAIL fresh_latency got=%0d exp=16", lat); end
    checks++; if (bus.opA !== 8'd67) begin failures++; $display("FAIL fresh_opA got=%0d exp=67", bus.opA); end
    checks++; if (bus.rem !== 8'd0 || bus.err !== 1'b0) begin failures++; $display("FAIL fresh_rem_err got=%0d/%b exp=0/0", bus.rem, bus.err); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 1'b0;
    bus.res    = 16'h0000;
    bus.opB    = 8'h00;
    test_reset;
    test_inv_add;
    test_inv_mul;
    test_boundaries;
    test_div_zero;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_div;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
